// File: rtl/mux4_arbiter_pkg.sv
// rtl/mux4_arbiter_pkg.sv - shared constants, state encoding and helpers for the 4-way arbiter
package mux4_arbiter_pkg;
  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/mux4_arbiter_pick.sv
// rtl/mux4_arbiter_pick.sv - round-robin pick: first unmasked request scanning from ptr
module rr_pick
  import mux4_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [NREQ-1:0]  exclude,
  output logic [SEL_W-1:0] index,
  output logic             found
);
  logic [NREQ-1:0]  masked;
  logic [SEL_W-1:0] cand;

  assign masked = req & ~exclude;

  always_comb begin
    found = 1'b0;
    index = ptr;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && masked[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end
endmodule

// File: rtl/mux4_arbiter.sv
// rtl/mux4_arbiter.sv - round-robin 4-way arbiter with dwell-limited preemption
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic [NREQ-1:0]    grant,
  output logic               valid,
  output logic               change
);
  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [NREQ-1:0]    grant_q;
  logic               valid_q;
  logic               change_q;
  logic [DWELL_W-1:0] cnt_q;

  logic [NREQ-1:0]    exclude;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               preempt;

  // While holding, the current grantee is never its own successor.
  assign exclude = (state_q == ST_HOLD) ? grant_q : '0;
  assign preempt = (dwell != '0) && (cnt_q >= dwell) && ((req & ~grant_q) != '0);

  rr_pick u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .exclude (exclude),
    .index   (pick_idx),
    .found   (pick_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      ptr_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      change_q <= 1'b0;
      if (state_q == ST_HOLD && req[sel_q] && !preempt) begin
        if (cnt_q != '1) cnt_q <= cnt_q + DWELL_W'(1);
      end else if (pick_found) begin
        state_q  <= ST_HOLD;
        sel_q    <= pick_idx;
        grant_q  <= onehot(pick_idx);
        valid_q  <= 1'b1;
        change_q <= (pick_idx != sel_q);
        ptr_q    <= pick_idx + SEL_W'(1);
        cnt_q    <= DWELL_W'(1);
      end else begin
        state_q <= ST_IDLE;
        grant_q <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign sel    = sel_q;
  assign grant  = grant_q;
  assign valid  = valid_q;
  assign change = change_q;
endmodule
